// File: rtl/lfsr_chain_readout.sv
// rtl/lfsr_chain_readout.sv - readout master for a column chain of 15-bit LFSR pixel counters
// Optional feature macro: CONFIG_LFSR_DECODE_EN (decode each raw LFSR word to its binary count)

module lfsr_chain_readout #(
    parameter int N_PIX = 256,
    parameter int GUARD = 2,
    localparam int IDX_W = (N_PIX > 1) ? $clog2(N_PIX) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             shutter,
    output logic             clk_read,
    output logic             chain_in,
    input  logic             chain_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [14:0]      out_data,
    output logic [IDX_W-1:0] out_pix,
    output logic             out_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_STALL,
        S_HOLD,
        S_HOLD_LOW,
        S_DONE
    } state_t;

    localparam logic [15:0]      GUARD_LAST = 16'(GUARD - 1);
    localparam logic [IDX_W-1:0] PIX_LAST   = IDX_W'(N_PIX - 1);

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             shutter_q, shutter_d;
    logic             clk_read_q, clk_read_d;
    logic             chain_in_q, chain_in_d;
    logic [14:0]      word_q, word_d;
    logic [14:0]      word_shift;
    logic [14:0]      load_word;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [15:0]      guard_cnt_q, guard_cnt_d;
    logic             load;
    logic             stage_free;
    logic             stage_empty;
    logic             guard_hit;

    // chain_out is b[15] of the last pixel; the first bit of each word is its MSB
    assign word_shift = {word_q[13:0], chain_out};
    assign guard_hit  = (guard_cnt_q == GUARD_LAST);

    // Sequencer next-state: shutter/clk_read pacing, deserialiser and hand-off to the output stage
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        shutter_d   = shutter_q;
        clk_read_d  = clk_read_q;
        chain_in_d  = chain_in_q;
        word_d      = word_q;
        bit_cnt_d   = bit_cnt_q;
        pix_cnt_d   = pix_cnt_q;
        guard_cnt_d = guard_cnt_q;
        load        = 1'b0;
        load_word   = word_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    state_d     = S_SETUP;
                    busy_d      = 1'b1;
                    shutter_d   = 1'b1;
                    chain_in_d  = 1'b1;
                    guard_cnt_d = 16'd0;
                    bit_cnt_d   = 4'd0;
                    pix_cnt_d   = PIX_LAST;
                end
            end
            S_SETUP: begin
                if (guard_hit) begin
                    state_d = S_SHIFT;
                end else begin
                    guard_cnt_d = guard_cnt_q + 16'd1;
                end
            end
            S_SHIFT: begin
                if (clk_read_q) begin
                    clk_read_d = 1'b0;
                end else begin
                    // sample before the pixels see the rising edge produced by this same clock
                    clk_read_d = 1'b1;
                    word_d     = word_shift;
                    if (bit_cnt_q == 4'd14) begin
                        bit_cnt_d = 4'd0;
                        if (stage_free) begin
                            load      = 1'b1;
                            load_word = word_shift;
                            if (pix_cnt_q == '0) begin
                                state_d     = S_HOLD;
                                guard_cnt_d = 16'd0;
                            end else begin
                                pix_cnt_d = pix_cnt_q - IDX_W'(1);
                            end
                        end else begin
                            state_d = S_STALL;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            S_STALL: begin
                // clk_read parked low so no bit is pushed out of the chain while we wait
                clk_read_d = 1'b0;
                if (stage_free) begin
                    load = 1'b1;
                    if (pix_cnt_q == '0) begin
                        state_d     = S_HOLD;
                        guard_cnt_d = 16'd0;
                    end else begin
                        state_d   = S_SHIFT;
                        pix_cnt_d = pix_cnt_q - IDX_W'(1);
                    end
                end
            end
            S_HOLD: begin
                clk_read_d = 1'b0;
                if (clk_read_q) begin
                    guard_cnt_d = 16'd0;
                end else if (guard_hit) begin
                    shutter_d   = 1'b0;
                    chain_in_d  = 1'b0;
                    guard_cnt_d = 16'd0;
                    state_d     = S_HOLD_LOW;
                end else begin
                    guard_cnt_d = guard_cnt_q + 16'd1;
                end
            end
            S_HOLD_LOW: begin
                if (guard_hit) begin
                    if (stage_empty) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    guard_cnt_d = guard_cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            shutter_q   <= 1'b0;
            clk_read_q  <= 1'b0;
            chain_in_q  <= 1'b0;
            word_q      <= 15'd0;
            bit_cnt_q   <= 4'd0;
            pix_cnt_q   <= '0;
            guard_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            shutter_q   <= shutter_d;
            clk_read_q  <= clk_read_d;
            chain_in_q  <= chain_in_d;
            word_q      <= word_d;
            bit_cnt_q   <= bit_cnt_d;
            pix_cnt_q   <= pix_cnt_d;
            guard_cnt_q <= guard_cnt_d;
        end
    end

    assign busy     = busy_q;
    assign done     = (state_q == S_DONE);
    assign shutter  = shutter_q;
    assign clk_read = clk_read_q;
    assign chain_in = chain_in_q;

`ifdef CONFIG_LFSR_DECODE_EN
    logic             dec_busy_q;
    logic [14:0]      dec_word_q;
    logic [14:0]      cand_q;
    logic [14:0]      cnt_q;
    logic             out_valid_q;
    logic [14:0]      out_data_q;
    logic [IDX_W-1:0] out_pix_q;
    logic             out_err_q;

    function automatic logic [14:0] lfsr_step(input logic [14:0] w);
        return {w[13:0], w[13] ^ w[14]};
    endfunction

    assign stage_free  = !dec_busy_q && (!out_valid_q || out_ready);
    assign stage_empty = !dec_busy_q && !out_valid_q;

    // Output stage with iterative decoder: walk the sequence from all-ones until it matches the word
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dec_busy_q  <= 1'b0;
            dec_word_q  <= 15'd0;
            cand_q      <= 15'h7FFF;
            cnt_q       <= 15'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 15'd0;
            out_pix_q   <= '0;
            out_err_q   <= 1'b0;
        end else if (load) begin
            dec_busy_q  <= 1'b1;
            dec_word_q  <= load_word;
            cand_q      <= 15'h7FFF;
            cnt_q       <= 15'd0;
            out_valid_q <= 1'b0;
            out_pix_q   <= pix_cnt_q;
            out_err_q   <= 1'b0;
        end else if (dec_busy_q) begin
            if (dec_word_q == 15'd0) begin
                // all-zeros is off the LFSR cycle; flag it instead of searching forever
                dec_busy_q  <= 1'b0;
                out_valid_q <= 1'b1;
                out_data_q  <= 15'd0;
                out_err_q   <= 1'b1;
            end else if (cand_q == dec_word_q) begin
                dec_busy_q  <= 1'b0;
                out_valid_q <= 1'b1;
                out_data_q  <= cnt_q;
            end else begin
                cand_q <= lfsr_step(cand_q);
                cnt_q  <= cnt_q + 15'd1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_pix   = out_pix_q;
    assign out_err   = out_err_q;
`else
    logic             out_valid_q;
    logic [14:0]      out_data_q;
    logic [IDX_W-1:0] out_pix_q;

    assign stage_free  = !out_valid_q || out_ready;
    assign stage_empty = !out_valid_q;

    // Single-entry raw output stage
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= 15'd0;
            out_pix_q   <= '0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= load_word;
            out_pix_q   <= pix_cnt_q;
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_pix   = out_pix_q;
    assign out_err   = 1'b0;
`endif

endmodule
